// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified-memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Word returned to the requester when the memory never answers
  localparam logic [63:0] TIMEOUT_DATA = '0;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// rtl/mem_arbiter_sat_counter.sv - saturating event counter used for per-port stall statistics
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count up on each flagged cycle, sticking at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_i,
  input  logic [AW-1:0]    if_addr_i,
  output logic             if_ack_o,
  output logic [DW-1:0]    if_data_o,
  output logic             if_stall_o,
  input  logic             dm_req_i,
  input  logic             dm_we_i,
  input  logic [AW-1:0]    dm_addr_i,
  input  logic [DW-1:0]    dm_wdata_i,
  output logic             dm_ack_o,
  output logic [DW-1:0]    dm_rdata_o,
  output logic             dm_stall_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [DW-1:0]    mem_rdata_i,
  output logic             err_o,
  output logic [CNT_W-1:0] if_stall_cnt_o,
  output logic [CNT_W-1:0] dm_stall_cnt_o
);

  localparam int BW = $clog2(TIMEOUT + 1);

  state_e        state_q,      state_d;
  owner_e        last_grant_q, last_grant_d;
  logic [BW-1:0] busy_cnt_q,   busy_cnt_d;
  logic [AW-1:0] addr_q,       addr_d;
  logic          we_q,         we_d;
  logic [DW-1:0] wdata_q,      wdata_d;
  logic          en_q,         en_d;
  logic          if_ack_q,     if_ack_d;
  logic          dm_ack_q,     dm_ack_d;
  logic [DW-1:0] if_data_q,    if_data_d;
  logic [DW-1:0] dm_data_q,    dm_data_d;
  logic          err_q,        err_d;

  logic          if_elig;
  logic          dm_elig;
  logic          grant_dm;
  logic          grant_if;
  logic          timed_out;

  // A port that is being acked this cycle still shows its old request; ignore it
  assign if_elig  = if_req_i & ~if_ack_q;
  assign dm_elig  = dm_req_i & ~dm_ack_q;
  assign grant_dm = dm_elig & (~if_elig | (last_grant_q != OWN_DM));
  assign grant_if = if_elig & ~grant_dm;
  assign timed_out = (busy_cnt_q == BW'(TIMEOUT));

  // Next-state, grant and completion logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    busy_cnt_d   = busy_cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    en_d         = 1'b0;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    if_data_d    = if_data_q;
    dm_data_d    = dm_data_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d      = BUSY_DM;
          last_grant_d = OWN_DM;
          busy_cnt_d   = BW'(1);
          addr_d       = {dm_addr_i[AW-1:2], 2'b00};
          we_d         = dm_we_i;
          wdata_d      = dm_wdata_i;
          en_d         = 1'b1;
        end else if (grant_if) begin
          state_d      = BUSY_IF;
          last_grant_d = OWN_IF;
          busy_cnt_d   = BW'(1);
          addr_d       = {if_addr_i[AW-1:2], 2'b00};
          we_d         = 1'b0;
          en_d         = 1'b1;
        end
      end
      BUSY_IF: begin
        if (mem_ack_i) begin
          state_d   = IDLE;
          if_ack_d  = 1'b1;
          if_data_d = mem_rdata_i;
        end else if (timed_out) begin
          state_d   = IDLE;
          if_ack_d  = 1'b1;
          if_data_d = TIMEOUT_DATA[DW-1:0];
          err_d     = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + BW'(1);
        end
      end
      BUSY_DM: begin
        if (mem_ack_i) begin
          state_d  = IDLE;
          dm_ack_d = 1'b1;
          if (!we_q) begin
            dm_data_d = mem_rdata_i;
          end
        end else if (timed_out) begin
          state_d   = IDLE;
          dm_ack_d  = 1'b1;
          dm_data_d = TIMEOUT_DATA[DW-1:0];
          err_d     = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_IF;
      busy_cnt_q   <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      en_q         <= 1'b0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_data_q    <= '0;
      dm_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      busy_cnt_q   <= busy_cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      en_q         <= en_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      if_data_q    <= if_data_d;
      dm_data_q    <= dm_data_d;
      err_q        <= err_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_data_o   = if_data_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign dm_rdata_o  = dm_data_q;
  assign dm_stall_o  = dm_req_i & ~dm_ack_q;
  assign mem_en_o    = en_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;

  sat_counter #(.CNT_W(CNT_W)) u_if_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (if_stall_o),
    .cnt_o (if_stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dm_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (dm_stall_o),
    .cnt_o (dm_stall_cnt_o)
  );

endmodule
